// File: rtl/nec_prefetch_pkg.sv
// Shared types for the NEC core prefetch queue.
package types;

    // Prefetch bus-cycle state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        DATA    = 2'd2
    } prefetch_state_e;

    // Queue depth in bytes and the width of the fill-level count (0..8)
    localparam int IPQ_DEPTH = 8;
    localparam int IPQ_LEN_W = 4;

    typedef logic [IPQ_LEN_W-1:0] ipq_len_t;

endpackage

// File: rtl/nec_prefetch.sv
// Instruction prefetch queue: 8-byte circular buffer indexed by code address
// bits [2:0], filled by word/byte bus fetches and drained by the decoder's pc.
module nec_prefetch
    import types::*;
(
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              ce_1,
    input  logic                              ce_2,
    input  logic [15:0]                       cs,
    input  logic [15:0]                       pc,
    input  logic [15:0]                       new_pc,
    input  logic                              set_pc,
    input  logic                              pause,
    output logic [IPQ_DEPTH-1:0][7:0]         ipq,
    output ipq_len_t                          ipq_len,
    output logic                              bus_req,
    output logic [19:0]                       bus_addr,
    output logic                              bus_wide,
    input  logic                              bus_ack,
    input  logic                              bus_rdy,
    input  logic [15:0]                       bus_data
);

    prefetch_state_e state, state_nxt;
    logic [15:0]     fetch_ip;
    logic            discard;
    logic            ce;
    logic            issue;
    logic            rdy_take;
    logic [3:0]      free;
    logic [11:0]     len_hi_unused;
    logic [2:0]      wr_lo, wr_hi;

    assign ce = ce_1 | ce_2;

    // Fill level is the distance from the consumer to the fetch pointer; the
    // upper bits are always zero because space is reserved at issue time.
    assign {len_hi_unused, ipq_len} = fetch_ip - pc;
    assign free = 4'd8 - ipq_len;

    // Even addresses need room for two bytes, odd addresses for one.
    assign issue = !pause && !set_pc &&
                   (fetch_ip[0] ? (free >= 4'd1) : (free >= 4'd2));

    // Returned data is kept only if no flush hit this cycle or an earlier one.
    assign rdy_take = (state == DATA) && bus_rdy && !discard && !set_pc;

    assign wr_lo = fetch_ip[2:0];
    assign wr_hi = wr_lo + 3'd1;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else if (ce)
            state <= state_nxt;
    end

    // Next-state: issue, wait for accept, wait for data
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue)   state_nxt = REQUEST;
            REQUEST: if (bus_ack) state_nxt = DATA;
            DATA:    if (bus_rdy) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // Bus request outputs, fetch pointer and discard flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_req  <= 1'b0;
            bus_addr <= 20'h0;
            bus_wide <= 1'b0;
            fetch_ip <= 16'h0;
            discard  <= 1'b0;
        end else if (ce) begin
            if (state == IDLE && issue) begin
                bus_req  <= 1'b1;
                bus_addr <= {cs, 4'h0} + {4'h0, fetch_ip};
                bus_wide <= ~fetch_ip[0];
            end
            if (state == REQUEST && bus_ack)
                bus_req <= 1'b0;

            if (rdy_take)
                fetch_ip <= fetch_ip + (bus_wide ? 16'd2 : 16'd1);
            if (state == DATA && bus_rdy)
                discard <= 1'b0;

            // A flush never cancels an accepted cycle; it just poisons its data.
            // When it lands on the rdy edge the cycle is already over.
            if (set_pc) begin
                fetch_ip <= new_pc;
                if (state == REQUEST || (state == DATA && !bus_rdy))
                    discard <= 1'b1;
            end
        end
    end

    // Queue storage: word data low byte at the even address, odd bytes on [15:8]
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ipq <= '0;
        end else if (ce && rdy_take) begin
            if (bus_wide) begin
                ipq[wr_lo] <= bus_data[7:0];
                ipq[wr_hi] <= bus_data[15:8];
            end else begin
                ipq[wr_lo] <= bus_data[15:8];
            end
        end
    end

endmodule

// File: tb/tb_nec_prefetch.sv
// Directed test of the prefetch queue: fill, flush, wrap, pause and ce gating.
module tb_nec_prefetch;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ce_1, ce_2;
    logic [15:0]       cs, pc, new_pc;
    logic              set_pc, pause;
    logic [7:0][7:0]   ipq;
    logic [3:0]        ipq_len;
    logic              bus_req;
    logic [19:0]       bus_addr;
    logic              bus_wide;
    logic              bus_ack, bus_rdy;
    logic [15:0]       bus_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    nec_prefetch dut (
        .clk(clk), .reset_n(reset_n), .ce_1(ce_1), .ce_2(ce_2),
        .cs(cs), .pc(pc), .new_pc(new_pc), .set_pc(set_pc), .pause(pause),
        .ipq(ipq), .ipq_len(ipq_len),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_wide(bus_wide),
        .bus_ack(bus_ack), .bus_rdy(bus_rdy), .bus_data(bus_data)
    );

    always #5 clk = ~clk;

    // Wait (bounded) for a pending request; no checking here.
    task automatic wait_req(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Complete one bus cycle: ack one edge, rdy with data on the next.
    task automatic serve(input logic [15:0] data, output logic [19:0] addr,
                         output logic wide, output logic ok);
        wait_req(ok);
        addr = bus_addr;
        wide = bus_wide;
        if (ok) begin
            bus_ack = 1'b1;
            @(negedge clk);
            bus_ack = 1'b0;
            bus_rdy = 1'b1;
            bus_data = data;
            @(negedge clk);
            bus_rdy = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; ce_1 = 1'b1; ce_2 = 1'b0;
        cs = 16'hF000; pc = 16'h0; new_pc = 16'h0; set_pc = 1'b0; pause = 1'b0;
        bus_ack = 1'b0; bus_rdy = 1'b0; bus_data = 16'h0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({bus_req, bus_addr, bus_wide} !== 22'h0)
            $display("FAIL reset_bus: got req=%0b addr=%05h wide=%0b want 0/00000/0", bus_req, bus_addr, bus_wide);
        else pass_cnt++;
        total_cnt++;
        if (ipq !== 64'h0 || ipq_len !== 4'd0)
            $display("FAIL reset_ipq: got ipq=%016h len=%0d want 0/0", ipq, ipq_len);
        else pass_cnt++;
        reset_n = 1'b1;
    endtask

    task automatic test_fill;
        logic [19:0] a; logic w, ok;
        logic [15:0] d [4] = '{16'h1100, 16'h3322, 16'h5544, 16'h7766};
        for (int i = 0; i < 4; i++) begin
            serve(d[i], a, w, ok);
            total_cnt++;
            if (!ok || a !== 20'hF0000 + 20'(2*i) || w !== 1'b1)
                $display("FAIL fill_req%0d: got ok=%0b addr=%05h wide=%0b want addr=%05h wide=1", i, ok, a, w, 20'hF0000 + 20'(2*i));
            else pass_cnt++;
        end
        total_cnt++;
        if (ipq !== 64'h7766554433221100 || ipq_len !== 4'd8)
            $display("FAIL fill_data: got ipq=%016h len=%0d want 7766554433221100/8", ipq, ipq_len);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (bus_req !== 1'b0)
            $display("FAIL fill_no_fifth: got req=%0b want 0", bus_req);
        else pass_cnt++;
    endtask

    task automatic test_consume;
        logic [19:0] a; logic w, ok;
        pc = 16'h0001;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (bus_req !== 1'b0 || ipq_len !== 4'd7)
            $display("FAIL consume_one: got req=%0b len=%0d want 0/7", bus_req, ipq_len);
        else pass_cnt++;
        pc = 16'h0002;
        serve(16'h9988, a, w, ok);
        total_cnt++;
        if (!ok || a !== 20'hF0008 || w !== 1'b1)
            $display("FAIL consume_two_req: got ok=%0b addr=%05h wide=%0b want F0008/1", ok, a, w);
        else pass_cnt++;
        total_cnt++;
        if (ipq !== 64'h7766554433229988 || ipq_len !== 4'd8)
            $display("FAIL consume_two_data: got ipq=%016h len=%0d want 7766554433229988/8", ipq, ipq_len);
        else pass_cnt++;
    endtask

    task automatic test_flush_odd;
        logic [19:0] a; logic w, ok;
        set_pc = 1'b1; new_pc = 16'h0003; pc = 16'h0003;
        @(negedge clk);
        set_pc = 1'b0;
        total_cnt++;
        if (ipq_len !== 4'd0)
            $display("FAIL flush_len: got %0d want 0", ipq_len);
        else pass_cnt++;
        serve(16'hAB00, a, w, ok);
        total_cnt++;
        if (!ok || a !== 20'hF0003 || w !== 1'b0)
            $display("FAIL flush_byte_req: got ok=%0b addr=%05h wide=%0b want F0003/0", ok, a, w);
        else pass_cnt++;
        total_cnt++;
        if (ipq[3] !== 8'hAB || ipq_len !== 4'd1)
            $display("FAIL flush_byte_data: got ipq[3]=%02h len=%0d want AB/1", ipq[3], ipq_len);
        else pass_cnt++;
        serve(16'hC5C4, a, w, ok);
        total_cnt++;
        if (!ok || a !== 20'hF0004 || w !== 1'b1 || ipq_len !== 4'd3)
            $display("FAIL flush_word_after: got ok=%0b addr=%05h wide=%0b len=%0d want F0004/1/3", ok, a, w, ipq_len);
        else pass_cnt++;
    endtask

    task automatic test_flush_in_data;
        logic [19:0] a; logic w, ok;
        wait_req(ok);
        total_cnt++;
        if (!ok || bus_addr !== 20'hF0006 || bus_wide !== 1'b1)
            $display("FAIL fdata_req: got ok=%0b addr=%05h wide=%0b want F0006/1", ok, bus_addr, bus_wide);
        else pass_cnt++;
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        set_pc = 1'b1; new_pc = 16'h0100; pc = 16'h0100;
        @(negedge clk);
        set_pc = 1'b0; bus_rdy = 1'b1; bus_data = 16'hDEAD;
        @(negedge clk);
        bus_rdy = 1'b0;
        total_cnt++;
        if (ipq !== 64'h7766C5C4AB229988 || ipq_len !== 4'd0 || bus_req !== 1'b0)
            $display("FAIL fdata_drop: got ipq=%016h len=%0d req=%0b want 7766C5C4AB229988/0/0", ipq, ipq_len, bus_req);
        else pass_cnt++;
        serve(16'h0201, a, w, ok);
        total_cnt++;
        if (!ok || a !== 20'hF0100 || w !== 1'b1 || ipq !== 64'h7766C5C4AB220201 || ipq_len !== 4'd2)
            $display("FAIL fdata_next: got ok=%0b addr=%05h wide=%0b ipq=%016h len=%0d want F0100/1/7766C5C4AB220201/2", ok, a, w, ipq, ipq_len);
        else pass_cnt++;
    endtask

    task automatic test_flush_on_rdy;
        logic [19:0] a; logic w, ok;
        wait_req(ok);
        total_cnt++;
        if (!ok || bus_addr !== 20'hF0102)
            $display("FAIL frdy_req: got ok=%0b addr=%05h want F0102", ok, bus_addr);
        else pass_cnt++;
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        bus_rdy = 1'b1; bus_data = 16'hBEEF;
        set_pc = 1'b1; new_pc = 16'h0200; pc = 16'h0200;
        @(negedge clk);
        bus_rdy = 1'b0; set_pc = 1'b0;
        total_cnt++;
        if (ipq !== 64'h7766C5C4AB220201 || ipq_len !== 4'd0 || bus_req !== 1'b0)
            $display("FAIL frdy_drop: got ipq=%016h len=%0d req=%0b want 7766C5C4AB220201/0/0", ipq, ipq_len, bus_req);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus_req !== 1'b1 || bus_addr !== 20'hF0200 || bus_wide !== 1'b1)
            $display("FAIL frdy_next: got req=%0b addr=%05h wide=%0b want 1/F0200/1", bus_req, bus_addr, bus_wide);
        else pass_cnt++;
        serve(16'h0403, a, w, ok);
        total_cnt++;
        if (!ok || ipq !== 64'h7766C5C4AB220403 || ipq_len !== 4'd2)
            $display("FAIL frdy_fill: got ok=%0b ipq=%016h len=%0d want 7766C5C4AB220403/2", ok, ipq, ipq_len);
        else pass_cnt++;
    endtask

    task automatic test_wrap_pause;
        logic [19:0] a; logic w, ok;
        set_pc = 1'b1; new_pc = 16'hFFFE; pc = 16'hFFFE; cs = 16'h1000; pause = 1'b1;
        @(negedge clk);
        set_pc = 1'b0;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (bus_req !== 1'b0 || ipq_len !== 4'd0)
            $display("FAIL pause_hold: got req=%0b len=%0d want 0/0", bus_req, ipq_len);
        else pass_cnt++;
        pause = 1'b0;
        serve(16'h0E0D, a, w, ok);
        total_cnt++;
        if (!ok || a !== 20'h1FFFE || w !== 1'b1)
            $display("FAIL wrap_req: got ok=%0b addr=%05h wide=%0b want 1FFFE/1", ok, a, w);
        else pass_cnt++;
        total_cnt++;
        if (ipq !== 64'h0E0DC5C4AB220403 || ipq_len !== 4'd2)
            $display("FAIL wrap_data: got ipq=%016h len=%0d want 0E0DC5C4AB220403/2", ipq, ipq_len);
        else pass_cnt++;
        wait_req(ok);
        pause = 1'b1;
        serve(16'h1211, a, w, ok);
        total_cnt++;
        if (!ok || a !== 20'h10000 || w !== 1'b1 || ipq !== 64'h0E0DC5C4AB221211 || ipq_len !== 4'd4)
            $display("FAIL wrap_next: got ok=%0b addr=%05h wide=%0b ipq=%016h len=%0d want 10000/1/0E0DC5C4AB221211/4", ok, a, w, ipq, ipq_len);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (bus_req !== 1'b0)
            $display("FAIL pause_after: got req=%0b want 0", bus_req);
        else pass_cnt++;
    endtask

    task automatic test_ce_and_reset;
        ce_1 = 1'b0; ce_2 = 1'b0; pause = 1'b0; pc = 16'h0002;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (bus_req !== 1'b0 || ipq_len !== 4'd0)
            $display("FAIL ce_gate: got req=%0b len=%0d want 0/0", bus_req, ipq_len);
        else pass_cnt++;
        ce_2 = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus_req !== 1'b1 || bus_addr !== 20'h10002)
            $display("FAIL ce2_issue: got req=%0b addr=%05h want 1/10002", bus_req, bus_addr);
        else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (bus_req !== 1'b0 || bus_addr !== 20'h0 || ipq !== 64'h0)
            $display("FAIL mid_reset: got req=%0b addr=%05h ipq=%016h want 0/0/0", bus_req, bus_addr, ipq);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_consume();
        test_flush_odd();
        test_flush_in_data();
        test_flush_on_rdy();
        test_wrap_pause();
        test_ce_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
